// File: rtl/bpred_ctrl_if.sv
// Fetch/execute handshake and BHT port bundle for bpred_ctrl.
// The slave modport is the controller side; master is the fetch/execute/BHT environment.
interface bpred_ctrl_if #(
    parameter int PC_W = 32,
    parameter int ADW  = 6
);
    logic            o_ready;
    logic            i_lkp_valid;
    logic [PC_W-1:0] i_lkp_pc;
    logic            o_pred_valid;
    logic            o_pred_taken;
    logic [PC_W-1:0] o_pred_pc;
    logic            i_res_valid;
    logic [PC_W-1:0] i_res_pc;
    logic            i_res_taken;
    logic            o_bht_rden0;
    logic [ADW-1:0]  o_bht_raddr0;
    logic [1:0]      i_bht_rdata0;
    logic            o_bht_rden1;
    logic [ADW-1:0]  o_bht_raddr1;
    logic [1:0]      i_bht_rdata1;
    logic            o_bht_wren;
    logic [ADW-1:0]  o_bht_waddr;
    logic [1:0]      o_bht_wdata;

    modport slave (
        output o_ready,
        input  i_lkp_valid, i_lkp_pc,
        output o_pred_valid, o_pred_taken, o_pred_pc,
        input  i_res_valid, i_res_pc, i_res_taken,
        output o_bht_rden0, o_bht_raddr0,
        input  i_bht_rdata0,
        output o_bht_rden1, o_bht_raddr1,
        input  i_bht_rdata1,
        output o_bht_wren, o_bht_waddr, o_bht_wdata
    );

    modport master (
        input  o_ready,
        output i_lkp_valid, i_lkp_pc,
        input  o_pred_valid, o_pred_taken, o_pred_pc,
        output i_res_valid, i_res_pc, i_res_taken,
        input  o_bht_rden0, o_bht_raddr0,
        output i_bht_rdata0,
        input  o_bht_rden1, o_bht_raddr1,
        output i_bht_rdata1,
        input  o_bht_wren, o_bht_waddr, o_bht_wdata
    );
endinterface

// File: rtl/bpred_ctrl.sv
// Branch predictor controller: 2-bit BHT lookups and forwarded saturating-counter updates.
// Define BPRED_INIT_EN to compile in the post-reset table sweep that writes RSTVAL to every entry.
module bpred_ctrl #(
    parameter int         DPT    = 64,
    parameter int         PC_W   = 32,
    parameter logic [1:0] RSTVAL = 2'b10
) (
    input  logic         clk,
    input  logic         areset,
    bpred_ctrl_if.slave  bus
);
    localparam int ADW = $clog2(DPT);

    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
        if (up)
            return (cnt == 2'b11) ? cnt : cnt + 2'b01;
        else
            return (cnt == 2'b00) ? cnt : cnt - 2'b01;
    endfunction

    logic            ready_q;
    logic            sw_wren;
    logic [ADW-1:0]  sw_addr;

    logic [ADW-1:0]  lkp_idx, res_idx;
    logic            lkp_acc, res_acc;

    logic            pred_vld_q;
    logic [PC_W-1:0] pred_pc_q;

    logic            u_vld_q, u_tkn_q;
    logic [ADW-1:0]  u_idx_q;
    logic            lw_vld_q;
    logic [ADW-1:0]  lw_addr_q;
    logic [1:0]      lw_data_q;

    logic            fwd_hit;
    logic [1:0]      u_base, u_new_d;
    logic            wren;
    logic [ADW-1:0]  waddr;
    logic [1:0]      wdata;

    logic            unused_pc_bits;
    assign unused_pc_bits = ^{bus.i_res_pc[PC_W-1:ADW+2], bus.i_res_pc[1:0], bus.i_bht_rdata0[0]};

`ifdef BPRED_INIT_EN
    typedef enum logic {S_INIT, S_RUN} state_t;
    state_t          state_q;
    logic            sw_wren_q;
    logic [ADW-1:0]  sw_addr_q;

    // Sweep walks 0..2**ADW-1 one entry per cycle, then enters RUN for good.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q   <= S_INIT;
            sw_wren_q <= 1'b0;
            sw_addr_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                S_INIT: begin
                    if (!sw_wren_q) begin
                        sw_wren_q <= 1'b1;
                    end else if (sw_addr_q == '1) begin
                        state_q   <= S_RUN;
                        sw_wren_q <= 1'b0;
                        ready_q   <= 1'b1;
                    end else begin
                        sw_addr_q <= sw_addr_q + ADW'(1);
                    end
                end
                default: ready_q <= 1'b1;
            endcase
        end
    end

    assign sw_wren = sw_wren_q;
    assign sw_addr = sw_addr_q;
`else
    always_ff @(posedge clk or posedge areset) begin
        if (areset) ready_q <= 1'b0;
        else        ready_q <= 1'b1;
    end

    assign sw_wren = 1'b0;
    assign sw_addr = '0;
`endif

    assign lkp_idx = bus.i_lkp_pc[ADW+1:2];
    assign res_idx = bus.i_res_pc[ADW+1:2];
    assign lkp_acc = bus.i_lkp_valid & ready_q;
    assign res_acc = bus.i_res_valid & ready_q;

    assign bus.o_ready      = ready_q;
    assign bus.o_bht_rden0  = lkp_acc;
    assign bus.o_bht_raddr0 = lkp_acc ? lkp_idx : '0;
    assign bus.o_bht_rden1  = res_acc;
    assign bus.o_bht_raddr1 = res_acc ? res_idx : '0;

    // Lookup stage: BHT read data lands alongside the registered PC.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            pred_vld_q <= 1'b0;
            pred_pc_q  <= '0;
        end else begin
            pred_vld_q <= lkp_acc;
            if (lkp_acc) pred_pc_q <= bus.i_lkp_pc;
        end
    end

    assign bus.o_pred_valid = pred_vld_q;
    assign bus.o_pred_taken = pred_vld_q & bus.i_bht_rdata0[1];
    assign bus.o_pred_pc    = pred_pc_q;

    // Stage R -> U boundary; the read issued in R returns during U.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            u_vld_q <= 1'b0;
            u_tkn_q <= 1'b0;
            u_idx_q <= '0;
        end else begin
            u_vld_q <= res_acc;
            u_tkn_q <= bus.i_res_taken;
            u_idx_q <= res_idx;
        end
    end

    // The RAM read in R missed a same-index write committed at that edge; take it from last-write.
    assign fwd_hit = lw_vld_q && (lw_addr_q == u_idx_q);
    assign u_base  = fwd_hit ? lw_data_q : bus.i_bht_rdata1;
    assign u_new_d = sat_step(u_base, u_tkn_q);

    assign wren  = sw_wren | u_vld_q;
    assign waddr = sw_wren ? sw_addr : u_idx_q;
    assign wdata = sw_wren ? RSTVAL : u_new_d;

    assign bus.o_bht_wren  = wren;
    assign bus.o_bht_waddr = wren ? waddr : '0;
    assign bus.o_bht_wdata = wren ? wdata : 2'b00;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            lw_vld_q  <= 1'b0;
            lw_addr_q <= '0;
            lw_data_q <= 2'b00;
        end else begin
            lw_vld_q  <= wren;
            lw_addr_q <= waddr;
            lw_data_q <= wdata;
        end
    end
endmodule

// File: tb/tb_bpred_ctrl.sv
// Self-checking bench for bpred_ctrl with a read-first behavioural BHT and a due-cycle scoreboard.
module tb_bpred_ctrl;
`ifdef BPRED_INIT_EN
    localparam int SWEEP   = 64;
    localparam bit DROP_TK = 1'b1;
`else
    localparam int SWEEP   = 0;
    localparam bit DROP_TK = 1'b0;
`endif

    typedef struct {
        bit          lv;
        logic [31:0] lpc;
        bit          ltk;
        bit          rv;
        logic [31:0] rpc;
        bit          rt;
        logic [1:0]  wd;
    } vec_t;

    typedef struct { int due; logic [31:0] pc; logic tk; } pred_t;
    typedef struct { int due; logic [5:0] a; logic [1:0] d; } wr_t;

    logic clk = 1'b0;
    logic areset = 1'b1;
    always #5 clk = ~clk;

    bpred_ctrl_if #(.PC_W(32), .ADW(6)) bus();

    bpred_ctrl #(.DPT(64), .PC_W(32), .RSTVAL(2'b10)) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus)
    );

    logic [1:0] mem [64];
    logic [1:0] rd0_q = 2'b00;
    logic [1:0] rd1_q = 2'b00;
    bit         mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 2'b10;
            mem_init <= 1'b1;
        end else if (bus.o_bht_wren) begin
            mem[bus.o_bht_waddr] <= bus.o_bht_wdata;
        end
        if (bus.o_bht_rden0) rd0_q <= mem[bus.o_bht_raddr0];
        if (bus.o_bht_rden1) rd1_q <= mem[bus.o_bht_raddr1];
    end
    assign bus.i_bht_rdata0 = rd0_q;
    assign bus.i_bht_rdata1 = rd1_q;

    int    cyc = 0;
    int    errors = 0;
    int    checks = 0;
    int    ready_from = 1 << 30;
    bit    in_rst = 1'b1;
    pred_t pq[$];
    wr_t   wq[$];
    vec_t  tv[$];

    function automatic vec_t row(bit lv, logic [31:0] lpc, bit ltk, bit rv, logic [31:0] rpc,
                                 bit rt, logic [1:0] wd);
        vec_t v;
        v.lv = lv; v.lpc = lpc; v.ltk = ltk;
        v.rv = rv; v.rpc = rpc; v.rt = rt; v.wd = wd;
        return v;
    endfunction
    function automatic vec_t idle();
        return row(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00);
    endfunction
    function automatic vec_t lkp(logic [31:0] pc, bit tk);
        return row(1'b1, pc, tk, 1'b0, 32'h0, 1'b0, 2'b00);
    endfunction
    function automatic vec_t res(logic [31:0] pc, bit t, logic [1:0] wd);
        return row(1'b0, 32'h0, 1'b0, 1'b1, pc, t, wd);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic cycle(input vec_t v);
        bit    rdy;
        pred_t p;
        wr_t   w;
        @(negedge clk);
        bus.i_lkp_valid = v.lv;
        bus.i_lkp_pc    = v.lpc;
        bus.i_res_valid = v.rv;
        bus.i_res_pc    = v.rpc;
        bus.i_res_taken = v.rt;
        #1;
        cyc++;
        rdy = !in_rst && (cyc >= ready_from);
        chk("ready", bus.o_ready, rdy);
        if (pq.size() != 0 && pq[0].due == cyc) begin
            p = pq.pop_front();
            chk("pred_valid", bus.o_pred_valid, 1'b1);
            chk("pred_pc", bus.o_pred_pc, p.pc);
            chk("pred_taken", bus.o_pred_taken, p.tk);
        end else begin
            chk("pred_valid_idle", bus.o_pred_valid, 1'b0);
        end
        if (wq.size() != 0 && wq[0].due == cyc) begin
            w = wq.pop_front();
            chk("wren", bus.o_bht_wren, 1'b1);
            chk("waddr", bus.o_bht_waddr, w.a);
            chk("wdata", bus.o_bht_wdata, w.d);
        end else begin
            chk("wren_idle", bus.o_bht_wren, 1'b0);
        end
        chk("rden0", bus.o_bht_rden0, v.lv && rdy);
        if (v.lv && rdy) begin
            chk("raddr0", bus.o_bht_raddr0, v.lpc[7:2]);
            pq.push_back('{cyc + 1, v.lpc, v.ltk});
        end
        chk("rden1", bus.o_bht_rden1, v.rv && rdy);
        if (v.rv && rdy) begin
            chk("raddr1", bus.o_bht_raddr1, v.rpc[7:2]);
            wq.push_back('{cyc + 1, v.rpc[7:2], v.wd});
        end
        if (in_rst) begin
            chk("rst_pred_pc", bus.o_pred_pc, 32'h0);
            chk("rst_raddr0", bus.o_bht_raddr0, 6'h0);
            chk("rst_waddr", bus.o_bht_waddr, 6'h0);
            chk("rst_wdata", bus.o_bht_wdata, 2'b00);
        end
    endtask

    task automatic assert_rst();
        #1;
        areset = 1'b1;
        in_rst = 1'b1;
        #1;
        chk("async_rst_wren", bus.o_bht_wren, 1'b0);
        chk("async_rst_ready", bus.o_ready, 1'b0);
        chk("async_rst_pred", bus.o_pred_valid, 1'b0);
        pq.delete();
        wq.delete();
    endtask

    task automatic release_rst();
        @(negedge clk);
        areset = 1'b0;
        in_rst = 1'b0;
        ready_from = cyc + 1 + SWEEP;
`ifdef BPRED_INIT_EN
        for (int i = 0; i < 64; i++) wq.push_back('{cyc + 1 + i, 6'(i), 2'b10});
`endif
    endtask

    initial begin
        // lookup basics
        tv.push_back(lkp(32'h14, 1'b1));          tv.push_back(idle());
        tv.push_back(res(32'h14, 1'b0, 2'b01));   tv.push_back(idle()); tv.push_back(idle());
        tv.push_back(lkp(32'h14, 1'b0));          tv.push_back(idle());
        // saturation up then down, spaced 3 cycles
        for (int k = 0; k < 4; k++) begin
            tv.push_back(res(32'h20, 1'b1, 2'b11)); tv.push_back(idle()); tv.push_back(idle());
        end
        tv.push_back(res(32'h20, 1'b0, 2'b10));   tv.push_back(idle()); tv.push_back(idle());
        tv.push_back(res(32'h20, 1'b0, 2'b01));   tv.push_back(idle()); tv.push_back(idle());
        tv.push_back(res(32'h20, 1'b0, 2'b00));   tv.push_back(idle()); tv.push_back(idle());
        tv.push_back(res(32'h20, 1'b0, 2'b00));   tv.push_back(idle()); tv.push_back(idle());
        // back-to-back forwarding on entry 7
        tv.push_back(res(32'h1C, 1'b0, 2'b01));   tv.push_back(idle()); tv.push_back(idle());
        tv.push_back(res(32'h1C, 1'b1, 2'b10));
        tv.push_back(res(32'h1C, 1'b1, 2'b11));
        tv.push_back(res(32'h1C, 1'b1, 2'b11));   tv.push_back(idle()); tv.push_back(idle());
        tv.push_back(lkp(32'h1C, 1'b1));          tv.push_back(idle());
        // concurrent lookup and resolution
        tv.push_back(row(1'b1, 32'h40, 1'b1, 1'b1, 32'h44, 1'b1, 2'b11));
        tv.push_back(idle()); tv.push_back(idle());
        tv.push_back(lkp(32'h44, 1'b1));          tv.push_back(idle());
        tv.push_back(row(1'b1, 32'h20, 1'b0, 1'b1, 32'h20, 1'b1, 2'b01));
        tv.push_back(idle()); tv.push_back(idle());
        tv.push_back(lkp(32'h20, 1'b0));          tv.push_back(idle());
        // top index with upper PC bits set
        tv.push_back(res(32'hFFFF_FFFC, 1'b0, 2'b01)); tv.push_back(idle()); tv.push_back(idle());
        tv.push_back(lkp(32'hFFFF_FFFC, 1'b0));   tv.push_back(idle());
        tv.push_back(res(32'h30, 1'b0, 2'b01));   tv.push_back(idle()); tv.push_back(idle());

        bus.i_lkp_valid = 1'b0; bus.i_lkp_pc = '0;
        bus.i_res_valid = 1'b0; bus.i_res_pc = '0; bus.i_res_taken = 1'b0;

        // reset state with requests pending
        cycle(row(1'b1, 32'h14, 1'b0, 1'b1, 32'h14, 1'b1, 2'b00));
        cycle(row(1'b1, 32'h14, 1'b0, 1'b1, 32'h14, 1'b1, 2'b00));
        release_rst();
        repeat (SWEEP) cycle(lkp(32'h14, 1'b1));
        cycle(idle());

        for (int i = 0; i < tv.size(); i++) cycle(tv[i]);

        // reset during a stage-U write drops it
        cycle(res(32'h30, 1'b1, 2'b10));
        cycle(idle());
        assert_rst();
        cycle(row(1'b1, 32'h30, 1'b0, 1'b1, 32'h30, 1'b1, 2'b00));
        release_rst();
        repeat (SWEEP) cycle(idle());
        cycle(idle());
        cycle(lkp(32'h30, DROP_TK));
        cycle(idle());

`ifdef BPRED_INIT_EN
        // reset at sweep address 30 restarts the sweep from 0
        assert_rst();
        cycle(idle());
        release_rst();
        repeat (31) cycle(idle());
        assert_rst();
        cycle(idle());
        release_rst();
        repeat (66) cycle(idle());
`endif

        repeat (3) cycle(idle());
        chk("pred_queue_drained", pq.size(), 0);
        chk("wr_queue_drained", wq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
